axis_out_serializer: RTL
========================

// Module: axis_out_serializer
// PURPOSE
//  Downstream stage of the matrix-multiply AXI-Stream top. Accepts one wide result beat
//  (NUM_WORDS x WORD_W bits, Q8.8 lanes) from the multiplier's m_axis port and replays it
//  as NUM_WORDS narrow WORD_W-bit beats toward the 64-bit DMA/host stream.
//  Preserves frame boundaries via tlast and counts completed frames.
// PARAMETERS
//  NUM_WORDS  9    narrow words per wide beat (wide width = NUM_WORDS*WORD_W)
//  WORD_W     64   narrow output data width
//  LANE_W     16   fixed-point lane width inside a word (Q8.8, two's complement)
// PORTS
//  aclk            in   1                  clock, all logic on rising edge
//  aresetn         in   1                  synchronous active-low reset
//  s_axis_tready   out  1                  wide-side ready
//  s_axis_tdata    in   NUM_WORDS*WORD_W   wide result beat
//  s_axis_tvalid   in   1                  wide-side valid
//  s_axis_tlast    in   1                  last wide beat of frame
//  m_axis_tready   in   1                  narrow-side ready
//  m_axis_tdata    out  WORD_W             narrow word
//  m_axis_tvalid   out  1                  narrow-side valid
//  m_axis_tlast    out  1                  last narrow word of frame
//  frame_count     out  32                 completed frames since reset
// BEHAVIOUR
//  - Reset (aresetn=0 at edge): held beat discarded, idx=0, state EMPTY, m_axis_tvalid=0,
//    m_axis_tlast=0, m_axis_tdata=0, frame_count=0; s_axis_tready forced 0 while aresetn=0.
//  - States: EMPTY (no beat held) / BUSY (beat held, idx = next word to emit, 0..NUM_WORDS-1).
//  - s_axis_tready = aresetn & (EMPTY | (idx==NUM_WORDS-1 & m_axis_tready)) -- combinational.
//  - Wide handshake (s_tvalid&s_tready): capture tdata and tlast into hold regs, idx<=0,
//    state<=BUSY. Latency: first narrow word valid the cycle after capture.
//  - In BUSY: m_axis_tvalid=1, m_axis_tdata = hold[idx*WORD_W +: WORD_W] (word 0 = bits
//    [WORD_W-1:0] first). Narrow handshake advances idx by 1.
//  - m_axis_tlast = held_last & (idx==NUM_WORDS-1); tlast never asserted on other words.
//  - Handshake of word NUM_WORDS-1: with no simultaneous wide handshake -> EMPTY; with one
//    -> stay BUSY, idx<=0, new beat loaded (no bubble; sustained 1 narrow word/cycle).
//  - frame_count += 1 on handshake of a word with m_axis_tlast=1; wraps 2^32-1 -> 0.
//  - m_axis_tready low: tdata/tlast/tvalid held stable (AXIS rule); no word dropped or repeated.
//  - s_axis_tvalid while BUSY and not on final word: tready=0, upstream stalls.
//  - Reset mid-frame: partial output abandoned, no tlast emitted, counter cleared.
// CONFIGURATION
//  OUT_RELU_EN defined: each LANE_W lane of m_axis_tdata with MSB=1 (negative) output as 0;
//  non-negative lanes pass unchanged; applied combinationally on the output word, no extra
//  latency. Undefined: m_axis_tdata is the raw held word, bit-exact.
// STRUCTURE
//  - Package axis_out_pkg: WORD_W/LANE_W/NUM_WORDS defaults, state enum {EMPTY,BUSY},
//    Q8.8 constants (ONE=16'h0100).
//  - One sub-module: lane_relu (WORD_W/LANE_W params, combinational per-lane clamp),
//    instantiated only under OUT_RELU_EN.
//  - Top holds: wide hold reg, held_last, idx counter ($clog2(NUM_WORDS) bits), state, frame_count.
// TESTING
//  1 Reset: aresetn=0 5 cycles with s_tvalid=1 -> s_tready=0, m_tvalid=0, frame_count=0.
//  2 Single beat, word i = 64'h0100*(i+1), tlast=1, m_tready=1 -> 9 words 0x0100..0x0900
//    on consecutive cycles, tlast only on 9th, frame_count=1.
//  3 Two back-to-back wide beats, tvalid held -> 18 narrow words, no idle cycle between;
//    tlast only on word 18 when only 2nd beat has tlast=1.
//  4 Backpressure: m_tready toggles 1,0,0,1,... -> data stable while stalled, order 0..8
//    intact, s_tready stays 0 until final word accepted.
//  5 ReLU: word0 = 64'hFF00_0100_8000_0200 -> 64'h0000_0100_0000_0200 with OUT_RELU_EN,
//    unchanged without.
//  6 Reset asserted after word 4 of a tlast beat -> no tlast seen, frame_count=0, next beat
//    starts at word 0.

Source files
------------

// File: rtl/axis_out_pkg.sv
// Shared definitions for the wide-to-narrow AXI-Stream output serializer:
// default geometry, serializer state encoding and Q8.8 constants.
package axis_out_pkg;

  localparam int DEF_NUM_WORDS = 9;
  localparam int DEF_WORD_W    = 64;
  localparam int DEF_LANE_W    = 16;

  // EMPTY: no wide beat held; BUSY: a wide beat is being replayed word by word.
  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  // Q8.8 fixed-point reference values.
  localparam logic [15:0] Q88_ONE  = 16'h0100;
  localparam logic [15:0] Q88_ZERO = 16'h0000;

  // Frame counter step; wraps naturally from 2^32-1 to 0.
  function automatic logic [31:0] frame_count_inc(input logic [31:0] count);
    return count + 32'd1;
  endfunction

endpackage

// File: rtl/lane_relu.sv
// Per-lane clamp of a narrow word: every LANE_W-bit two's complement lane
// that is negative is replaced by zero, non-negative lanes pass unchanged.
// Purely combinational.
module lane_relu #(
  parameter int WORD_W = 64,
  parameter int LANE_W = 16
) (
  input  logic [WORD_W-1:0] in_word,
  output logic [WORD_W-1:0] out_word
);

  localparam int LANES = WORD_W / LANE_W;

  // Clamp each lane whose sign bit is set.
  always_comb begin
    out_word = '0;
    for (int l = 0; l < LANES; l++) begin
      if (in_word[l*LANE_W + LANE_W - 1]) begin
        out_word[l*LANE_W +: LANE_W] = '0;
      end else begin
        out_word[l*LANE_W +: LANE_W] = in_word[l*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/axis_out_serializer.sv
// Accepts one wide result beat (NUM_WORDS x WORD_W bits) and replays it as
// NUM_WORDS narrow beats, word 0 (lowest bits) first, tlast only on the final
// word of a beat that carried tlast. Counts completed frames.
// Optional feature macro: OUT_RELU_EN -- clamps negative Q8.8 lanes of the
// output word to zero without adding latency.
module axis_out_serializer
  import axis_out_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int LANE_W    = DEF_LANE_W
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  output logic                          s_axis_tready,
  input  logic [NUM_WORDS*WORD_W-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [WORD_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [31:0]                   frame_count
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t                        state_r;
  logic [NUM_WORDS*WORD_W-1:0]   hold_r;
  logic                          held_last_r;
  logic [IDX_W-1:0]              idx_r;
  logic [31:0]                   frame_count_r;

  logic                          on_last_word_s;
  logic                          s_hs_s;
  logic                          m_hs_s;
  logic [WORD_W-1:0]             held_word_s;
  logic [WORD_W-1:0]             out_word_s;

  assign on_last_word_s = (state_r == BUSY) && (idx_r == LAST_IDX);

  // A new wide beat is taken when nothing is held, or when the final word
  // leaves in this very cycle (keeps one narrow word per cycle sustained).
  assign s_axis_tready = aresetn &&
                         ((state_r == EMPTY) || ((idx_r == LAST_IDX) && m_axis_tready));
  assign s_hs_s        = s_axis_tvalid && s_axis_tready;
  assign m_hs_s        = m_axis_tvalid && m_axis_tready;

  assign m_axis_tvalid = (state_r == BUSY);
  assign m_axis_tlast  = on_last_word_s && held_last_r;
  assign frame_count   = frame_count_r;

  // Select the word currently being presented from the held wide beat.
  always_comb begin
    held_word_s = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (idx_r == IDX_W'(w)) begin
        held_word_s = hold_r[w*WORD_W +: WORD_W];
      end else begin
        held_word_s = held_word_s;
      end
    end
  end

`ifdef OUT_RELU_EN
  lane_relu #(
    .WORD_W (WORD_W),
    .LANE_W (LANE_W)
  ) u_lane_relu (
    .in_word  (held_word_s),
    .out_word (out_word_s)
  );
`else
  for (genvar l = 0; l < WORD_W / LANE_W; l++) begin : g_raw_lane
    assign out_word_s[l*LANE_W +: LANE_W] = held_word_s[l*LANE_W +: LANE_W];
  end
`endif

  // Data bus reads zero whenever no word is being offered.
  assign m_axis_tdata = (state_r == BUSY) ? out_word_s : '0;

  // Serializer state, hold registers, word index and frame counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r       <= EMPTY;
      hold_r        <= '0;
      held_last_r   <= 1'b0;
      idx_r         <= '0;
      frame_count_r <= 32'd0;
    end else begin
      if (s_hs_s) begin
        hold_r      <= s_axis_tdata;
        held_last_r <= s_axis_tlast;
        idx_r       <= '0;
        state_r     <= BUSY;
      end else if (m_hs_s) begin
        if (idx_r == LAST_IDX) begin
          idx_r   <= '0;
          state_r <= EMPTY;
        end else begin
          idx_r   <= idx_r + IDX_W'(1);
          state_r <= BUSY;
        end
      end else begin
        state_r <= state_r;
      end

      if (m_hs_s && m_axis_tlast) begin
        frame_count_r <= frame_count_inc(frame_count_r);
      end else begin
        frame_count_r <= frame_count_r;
      end
    end
  end

endmodule
